// File: rtl/model_table_if.sv
// Descriptor-stream handshake between the DPR and model_table.
// MT_SAMPLE_EN adds the asn_done sideband used for DONE beats.
interface model_table_if #(
    parameter int OPC_W    = 8,
    parameter int HANDLE_W = 32
);
    logic                valid;
    logic                ready;
    logic [2:0]          field;
    logic [OPC_W-1:0]    opcode;
    logic [HANDLE_W-1:0] handle;
`ifdef MT_SAMPLE_EN
    logic                done;

    modport master (
        output valid, field, opcode, handle, done,
        input  ready
    );
    modport slave (
        input  valid, field, opcode, handle, done,
        output ready
    );
`else
    modport master (
        output valid, field, opcode, handle,
        input  ready
    );
    modport slave (
        input  valid, field, opcode, handle,
        output ready
    );
`endif
endinterface

// File: rtl/model_table.sv
// Model/layer descriptor table with field-order checking and a read port.
// Optional MT_SAMPLE_EN: SAMPLE field (code 7), sideband DONE, sample_ptr.
module model_table #(
    parameter int               NUM_LAYERS  = 16,
    parameter int               HANDLE_W    = 32,
    parameter int               OPC_W       = 8,
    parameter logic [OPC_W-1:0] FLATTEN_OPC = 8'd3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    model_table_if.slave                  asn,
    output logic                          o_asn_err,
    output logic [HANDLE_W-1:0]           o_model_ptr,
    output logic [$clog2(NUM_LAYERS):0]   o_num_layers,
    output logic                          o_assigned,
`ifdef MT_SAMPLE_EN
    output logic [HANDLE_W-1:0]           o_sample_ptr,
`endif
    input  logic                          i_rd_en,
    input  logic [$clog2(NUM_LAYERS)-1:0] i_rd_layer,
    output logic                          o_rd_valid,
    output logic                          o_rd_hit,
    output logic [OPC_W-1:0]              o_rd_opcode,
    output logic [HANDLE_W-1:0]           o_rd_scratch,
    output logic [HANDLE_W-1:0]           o_rd_weight,
    output logic [HANDLE_W-1:0]           o_rd_wgrad,
    output logic [HANDLE_W-1:0]           o_rd_bias,
    output logic [HANDLE_W-1:0]           o_rd_bgrad
);
    localparam int IDX_W = $clog2(NUM_LAYERS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [3:0] {
        S_UNASSIGNED,
`ifdef MT_SAMPLE_EN
        S_EXP_SAMPLE,
`endif
        S_EXP_LAYER,
        S_EXP_SCRATCH,
        S_EXP_WEIGHT,
        S_EXP_WGRAD,
        S_EXP_BIAS,
        S_EXP_BGRAD,
        S_LAYER_END,
        S_ASSIGNED
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_num;
    logic [HANDLE_W-1:0] r_model;
    logic                r_err;

    logic [OPC_W-1:0]    r_opc [NUM_LAYERS];
    logic [HANDLE_W-1:0] r_scr [NUM_LAYERS];
    logic [HANDLE_W-1:0] r_wgt [NUM_LAYERS];
    logic [HANDLE_W-1:0] r_wgr [NUM_LAYERS];
    logic [HANDLE_W-1:0] r_bia [NUM_LAYERS];
    logic [HANDLE_W-1:0] r_bgr [NUM_LAYERS];

    logic                r_rd_valid;
    logic                r_rd_hit;
    logic [OPC_W-1:0]    r_rd_opc;
    logic [HANDLE_W-1:0] r_rd_scr;
    logic [HANDLE_W-1:0] r_rd_wgt;
    logic [HANDLE_W-1:0] r_rd_wgr;
    logic [HANDLE_W-1:0] r_rd_bia;
    logic [HANDLE_W-1:0] r_rd_bgr;

    logic                w_ready;
    logic                w_fire;
    logic                w_done;
    logic [6:0]          w_f;
    logic [IDX_W-1:0]    w_idx;
    logic                w_full;
    logic                w_rd_hit;
    logic                w_err;
    logic                w_we_layer;
    logic [4:0]          w_we_h;
    logic                w_inc;
    logic                w_ld_model;

`ifdef MT_SAMPLE_EN
    logic                w_sample;
    logic                w_ld_sample;
    logic [HANDLE_W-1:0] r_sample;

    assign w_done   = asn.done;
    assign w_sample = !asn.done && (asn.field == 3'd7);
`else
    assign w_done   = (asn.field == 3'd7);
`endif

    // One-hot field decode; a DONE beat never matches a data field
    assign w_f      = w_done ? 7'b0 : 7'(8'b1 << asn.field);
    assign w_ready  = (r_state != S_ASSIGNED);
    assign w_fire   = asn.valid && w_ready && !i_clear && !rst;
    assign w_idx    = r_num[IDX_W-1:0];
    assign w_full   = (r_num == CNT_W'(NUM_LAYERS));
    assign w_rd_hit = ({1'b0, i_rd_layer} < r_num);

    always_comb begin
        w_next      = r_state;
        w_err       = 1'b0;
        w_we_layer  = 1'b0;
        w_we_h      = 5'b0;
        w_inc       = 1'b0;
        w_ld_model  = 1'b0;
`ifdef MT_SAMPLE_EN
        w_ld_sample = 1'b0;
`endif
        if (w_fire) begin
            case (r_state)
                S_UNASSIGNED: begin
                    if (w_f[0]) begin
                        w_ld_model = 1'b1;
`ifdef MT_SAMPLE_EN
                        w_next     = S_EXP_SAMPLE;
`else
                        w_next     = S_EXP_LAYER;
`endif
                    end else w_err = 1'b1;
                end
`ifdef MT_SAMPLE_EN
                S_EXP_SAMPLE: begin
                    if (w_sample) begin
                        w_ld_sample = 1'b1;
                        w_next      = S_EXP_LAYER;
                    end else w_err = 1'b1;
                end
`endif
                S_EXP_LAYER: begin
                    if (w_f[1]) begin
                        w_we_layer = 1'b1;
                        w_next     = S_EXP_SCRATCH;
                    end else w_err = 1'b1;
                end
                S_EXP_SCRATCH: begin
                    if (w_f[2]) begin
                        w_we_h[0] = 1'b1;
                        if (r_opc[w_idx] == FLATTEN_OPC) begin
                            w_inc  = 1'b1;
                            w_next = S_LAYER_END;
                        end else w_next = S_EXP_WEIGHT;
                    end else w_err = 1'b1;
                end
                S_EXP_WEIGHT: begin
                    if (w_f[3]) begin
                        w_we_h[1] = 1'b1;
                        w_next    = S_EXP_WGRAD;
                    end else w_err = 1'b1;
                end
                S_EXP_WGRAD: begin
                    if (w_f[4]) begin
                        w_we_h[2] = 1'b1;
                        w_next    = S_EXP_BIAS;
                    end else w_err = 1'b1;
                end
                S_EXP_BIAS: begin
                    if (w_f[5]) begin
                        w_we_h[3] = 1'b1;
                        w_next    = S_EXP_BGRAD;
                    end else w_err = 1'b1;
                end
                S_EXP_BGRAD: begin
                    if (w_f[6]) begin
                        w_we_h[4] = 1'b1;
                        w_inc     = 1'b1;
                        w_next    = S_LAYER_END;
                    end else w_err = 1'b1;
                end
                S_LAYER_END: begin
                    if (w_f[1] && !w_full) begin
                        w_we_layer = 1'b1;
                        w_next     = S_EXP_SCRATCH;
                    end else if (w_done) begin
                        w_next = S_ASSIGNED;
                    end else w_err = 1'b1;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) r_state <= S_UNASSIGNED;
        else                r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_num   <= '0;
            r_model <= '0;
            r_err   <= 1'b0;
`ifdef MT_SAMPLE_EN
            r_sample <= '0;
`endif
        end else begin
            r_err <= w_err;
            if (w_inc)      r_num   <= r_num + 1'b1;
            if (w_ld_model) r_model <= asn.handle;
`ifdef MT_SAMPLE_EN
            if (w_ld_sample) r_sample <= asn.handle;
`endif
        end
    end

    // Table storage is not reset; entries >= r_num are never reported
    always_ff @(posedge clk) begin
        if (w_we_layer) begin
            r_opc[w_idx] <= asn.opcode;
            r_wgt[w_idx] <= '0;
            r_wgr[w_idx] <= '0;
            r_bia[w_idx] <= '0;
            r_bgr[w_idx] <= '0;
        end
        if (w_we_h[0]) r_scr[w_idx] <= asn.handle;
        if (w_we_h[1]) r_wgt[w_idx] <= asn.handle;
        if (w_we_h[2]) r_wgr[w_idx] <= asn.handle;
        if (w_we_h[3]) r_bia[w_idx] <= asn.handle;
        if (w_we_h[4]) r_bgr[w_idx] <= asn.handle;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_opc   <= '0;
            r_rd_scr   <= '0;
            r_rd_wgt   <= '0;
            r_rd_wgr   <= '0;
            r_rd_bia   <= '0;
            r_rd_bgr   <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_hit <= w_rd_hit;
                r_rd_opc <= w_rd_hit ? r_opc[i_rd_layer] : '0;
                r_rd_scr <= w_rd_hit ? r_scr[i_rd_layer] : '0;
                r_rd_wgt <= w_rd_hit ? r_wgt[i_rd_layer] : '0;
                r_rd_wgr <= w_rd_hit ? r_wgr[i_rd_layer] : '0;
                r_rd_bia <= w_rd_hit ? r_bia[i_rd_layer] : '0;
                r_rd_bgr <= w_rd_hit ? r_bgr[i_rd_layer] : '0;
            end
        end
    end

    assign asn.ready    = w_ready;
    assign o_asn_err    = r_err;
    assign o_model_ptr  = r_model;
    assign o_num_layers = r_num;
    assign o_assigned   = (r_state == S_ASSIGNED);
`ifdef MT_SAMPLE_EN
    assign o_sample_ptr = r_sample;
`endif
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_hit     = r_rd_hit;
    assign o_rd_opcode  = r_rd_opc;
    assign o_rd_scratch = r_rd_scr;
    assign o_rd_weight  = r_rd_wgt;
    assign o_rd_wgrad   = r_rd_wgr;
    assign o_rd_bias    = r_rd_bia;
    assign o_rd_bgrad   = r_rd_bgr;
endmodule
